// File: rtl/compositor_pkg.sv
// Shared colour constants, fade FSM state type and sizing helpers for the layer compositor.
package compositor_pkg;

  localparam logic [11:0] BLACK   = 12'h000;
  localparam logic [11:0] WHITE   = 12'hFFF;
  localparam logic [11:0] MAGENTA = 12'hF0F;

  typedef enum logic [1:0] {
    BRIGHT   = 2'd0,
    FADE_OUT = 2'd1,
    DARK     = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  function automatic int fade_max(input int bits);
    return (1 << bits) - 1;
  endfunction

  // hit_id value meaning "no enabled layer covers this pixel"
  function automatic int hit_none(input int layer_num);
    return layer_num;
  endfunction

endpackage

// File: rtl/layer_prio_mux.sv
// Combinational priority select across layers; lowest index that is on wins.
module layer_prio_mux
  import compositor_pkg::*;
#(
  parameter int                     LAYER_NUM   = 6,
  parameter int                     PIXEL_WIDTH = 12,
  parameter logic [PIXEL_WIDTH-1:0] BG_COLOR    = BLACK,
  parameter int                     ID_W        = $clog2(LAYER_NUM + 1)
) (
  input  logic [LAYER_NUM-1:0]             on,
  input  logic [LAYER_NUM*PIXEL_WIDTH-1:0] rgb_in,
  output logic [PIXEL_WIDTH-1:0]           rgb,
  output logic [ID_W-1:0]                  id
);

  // Walk from lowest priority upward so the last assignment is the winner.
  always_comb begin
    rgb = BG_COLOR;
    id  = ID_W'(hit_none(LAYER_NUM));
    for (int i = LAYER_NUM - 1; i >= 0; i--) begin
      if (on[i]) begin
        rgb = rgb_in[i*PIXEL_WIDTH +: PIXEL_WIDTH];
        id  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Three-stage N-layer pixel compositor with frame-latched layer mask and frame-stepped fade.
// Optional feature: define TRANSPARENT_KEY_EN to treat KEY_COLOR pixels as uncovered.
//
//  state    | meaning
//  BRIGHT   | full brightness, waiting for fade_out_req
//  FADE_OUT | stepping level down one per FADE_STEP_FRAMES frame starts
//  DARK     | level 0, waiting for fade_in_req
//  FADE_IN  | stepping level up one per FADE_STEP_FRAMES frame starts
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int                     LAYER_NUM        = 6,
  parameter int                     PIXEL_WIDTH      = 12,
  parameter logic [PIXEL_WIDTH-1:0] BG_COLOR         = BLACK,
  parameter int                     FADE_BITS        = 4,
  parameter int                     FADE_STEP_FRAMES = 2,
  parameter logic [PIXEL_WIDTH-1:0] KEY_COLOR        = MAGENTA
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic                             video_on,
  input  logic                             frame_start,
  input  logic [LAYER_NUM-1:0]             layer_on,
  input  logic [LAYER_NUM*PIXEL_WIDTH-1:0] layer_rgb,
  input  logic                             layer_mask_wr,
  input  logic [LAYER_NUM-1:0]             layer_mask_in,
  input  logic                             fade_out_req,
  input  logic                             fade_in_req,
  output logic [PIXEL_WIDTH-1:0]           rgb,
  output logic                             rgb_valid,
  output logic [$clog2(LAYER_NUM+1)-1:0]   hit_id,
  output logic [FADE_BITS-1:0]             fade_level,
  output logic                             fade_busy
);

  localparam int ID_W   = $clog2(LAYER_NUM + 1);
  localparam int CH_W   = PIXEL_WIDTH / 3;
  localparam int PROD_W = CH_W + FADE_BITS + 1;
  localparam int CNT_W  = $clog2(FADE_STEP_FRAMES + 1);

  localparam logic [ID_W-1:0]      HIT_NONE = ID_W'(hit_none(LAYER_NUM));
  localparam logic [FADE_BITS-1:0] LVL_MAX  = FADE_BITS'(fade_max(FADE_BITS));
  localparam logic [FADE_BITS-1:0] LVL_ONE  = FADE_BITS'(1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FADE_STEP_FRAMES - 1);

  logic [LAYER_NUM-1:0] shadow_mask, active_mask;
  logic [LAYER_NUM-1:0] key_hit;

  logic                             v1;
  logic [LAYER_NUM-1:0]             on1;
  logic [LAYER_NUM*PIXEL_WIDTH-1:0] rgb1;

  logic                   v2;
  logic [PIXEL_WIDTH-1:0] rgb2, sel_rgb;
  logic [ID_W-1:0]        id2, sel_id;
  logic [PIXEL_WIDTH-1:0] faded;

  fade_state_t      state;
  logic [CNT_W-1:0] frame_cnt;

  // A write coinciding with frame_start bypasses the shadow so it takes effect this frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shadow_mask <= '1;
      active_mask <= '1;
    end else begin
      if (layer_mask_wr) shadow_mask <= layer_mask_in;
      if (frame_start)   active_mask <= layer_mask_wr ? layer_mask_in : shadow_mask;
    end
  end

`ifdef TRANSPARENT_KEY_EN
  always_comb begin
    key_hit = '0;
    for (int i = 0; i < LAYER_NUM; i++)
      key_hit[i] = (layer_rgb[i*PIXEL_WIDTH +: PIXEL_WIDTH] == KEY_COLOR);
  end
`else
  assign key_hit = '0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      v1   <= 1'b0;
      on1  <= '0;
      rgb1 <= '0;
    end else begin
      v1   <= video_on;
      on1  <= layer_on & active_mask & ~key_hit;
      rgb1 <= layer_rgb;
    end
  end

  layer_prio_mux #(
    .LAYER_NUM   (LAYER_NUM),
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .BG_COLOR    (BG_COLOR),
    .ID_W        (ID_W)
  ) u_prio_mux (
    .on     (on1),
    .rgb_in (rgb1),
    .rgb    (sel_rgb),
    .id     (sel_id)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      v2   <= 1'b0;
      rgb2 <= '0;
      id2  <= HIT_NONE;
    end else begin
      v2   <= v1;
      rgb2 <= sel_rgb;
      id2  <= sel_id;
    end
  end

  // Scale by (level+1)/2**FADE_BITS so the top level is exact identity.
  always_comb begin
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] gain;
    faded = '0;
    prod  = '0;
    gain  = PROD_W'(fade_level) + PROD_W'(1);
    for (int c = 0; c < 3; c++) begin
      prod = PROD_W'(rgb2[c*CH_W +: CH_W]) * gain;
      faded[c*CH_W +: CH_W] = CH_W'(prod >> FADE_BITS);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rgb_valid <= 1'b0;
      rgb       <= '0;
      hit_id    <= HIT_NONE;
    end else begin
      rgb_valid <= v2;
      rgb       <= v2 ? faded : '0;
      hit_id    <= id2;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= BRIGHT;
      fade_level <= LVL_MAX;
      frame_cnt  <= '0;
      fade_busy  <= 1'b0;
    end else begin
      case (state)
        BRIGHT: if (fade_out_req) begin
          state     <= FADE_OUT;
          frame_cnt <= '0;
          fade_busy <= 1'b1;
        end
        DARK: if (fade_in_req) begin
          state     <= FADE_IN;
          frame_cnt <= '0;
          fade_busy <= 1'b1;
        end
        FADE_OUT: if (frame_start) begin
          if (frame_cnt == CNT_LAST) begin
            frame_cnt  <= '0;
            fade_level <= fade_level - LVL_ONE;
            if (fade_level == LVL_ONE) begin
              state     <= DARK;
              fade_busy <= 1'b0;
            end
          end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        FADE_IN: if (frame_start) begin
          if (frame_cnt == CNT_LAST) begin
            frame_cnt  <= '0;
            fade_level <= fade_level + LVL_ONE;
            if (fade_level == LVL_MAX - LVL_ONE) begin
              state     <= BRIGHT;
              fade_busy <= 1'b0;
            end
          end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        default: state <= BRIGHT;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_layer_compositor;
  import compositor_pkg::*;

  localparam int          LN    = 6;
  localparam int          PW    = 12;
  localparam int          FB    = 4;
  localparam int          STEP  = 2;
  localparam int          NONE  = LN;
  localparam int          LMAX  = 15;
  localparam logic [11:0] BG    = 12'h00F;
  localparam logic [11:0] KEY   = 12'hF0F;

  logic              sys_clk, sys_rst, video_on, frame_start;
  logic [LN-1:0]     layer_on, layer_mask_in;
  logic [LN*PW-1:0]  layer_rgb;
  logic              layer_mask_wr, fade_out_req, fade_in_req;
  logic [PW-1:0]     rgb;
  logic              rgb_valid;
  logic [2:0]        hit_id;
  logic [FB-1:0]     fade_level;
  logic              fade_busy;

  layer_compositor #(
    .LAYER_NUM(LN), .PIXEL_WIDTH(PW), .BG_COLOR(BG), .FADE_BITS(FB),
    .FADE_STEP_FRAMES(STEP), .KEY_COLOR(KEY)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .video_on(video_on), .frame_start(frame_start),
    .layer_on(layer_on), .layer_rgb(layer_rgb), .layer_mask_wr(layer_mask_wr),
    .layer_mask_in(layer_mask_in), .fade_out_req(fade_out_req), .fade_in_req(fade_in_req),
    .rgb(rgb), .rgb_valid(rgb_valid), .hit_id(hit_id), .fade_level(fade_level),
    .fade_busy(fade_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [LN-1:0] m_shadow, m_active;
  int  m_mode;   // 0 bright, 1 fading out, 2 dark, 3 fading in
  int  m_level, m_frames, cyc;
  int  sl_valid[4], sl_rgb[4], sl_id[4];
  int  e_rgb, e_valid, e_id, e_level, e_busy;
  bit  model_ok = 1'b0;

  function automatic int scale(input int c, input int lvl);
    int r = 0;
    for (int ch = 0; ch < 3; ch++) begin
      int v = (c >> (4 * ch)) & 15;
      r |= ((v * (lvl + 1)) / 16) << (4 * ch);
    end
    return r;
  endfunction

  always @(posedge sys_clk) begin : model
    logic [LN-1:0] eff;
    int idx, k, sid, srgb, lv_before;
    idx = cyc % 4;
    eff = layer_on & m_active;
`ifdef TRANSPARENT_KEY_EN
    for (int i = 0; i < LN; i++) if (layer_rgb[i*PW +: PW] == KEY) eff[i] = 1'b0;
`endif
    sid = NONE;
    srgb = BG;
    for (int i = 0; i < LN; i++)
      if (eff[i] && sid == NONE) begin sid = i; srgb = layer_rgb[i*PW +: PW]; end
    sl_valid[idx] = video_on;
    sl_id[idx]    = sid;
    sl_rgb[idx]   = srgb;
    lv_before     = m_level;
    if (sys_rst) begin
      for (int j = 0; j < 3; j++) begin
        sl_valid[(cyc + 4 - j) % 4] = 0;
        sl_id[(cyc + 4 - j) % 4]    = NONE;
        sl_rgb[(cyc + 4 - j) % 4]   = 0;
      end
      m_shadow = '1; m_active = '1;
      m_mode = 0; m_level = LMAX; m_frames = 0;
      lv_before = LMAX;
      model_ok = 1'b1;
    end else begin
      if (frame_start) m_active = layer_mask_wr ? layer_mask_in : m_shadow;
      if (layer_mask_wr) m_shadow = layer_mask_in;
      if (m_mode == 0 && fade_out_req) begin m_mode = 1; m_frames = 0; end
      else if (m_mode == 2 && fade_in_req) begin m_mode = 3; m_frames = 0; end
      else if ((m_mode == 1 || m_mode == 3) && frame_start) begin
        m_frames++;
        if (m_frames == STEP) begin
          m_frames = 0;
          m_level += (m_mode == 1) ? -1 : 1;
          if (m_level == 0) m_mode = 2;
          if (m_level == LMAX) m_mode = 0;
        end
      end
    end
    k = (cyc + 2) % 4;
    e_valid = sl_valid[k];
    e_id    = sl_id[k];
    e_rgb   = e_valid ? scale(sl_rgb[k], lv_before) : 0;
    e_level = m_level;
    e_busy  = (m_mode == 1 || m_mode == 3) ? 1 : 0;
    cyc++;
  end

  always @(negedge sys_clk) begin
    if (model_ok) begin
      check("rgb", 32'(rgb), 32'(e_rgb));
      check("rgb_valid", 32'(rgb_valid), 32'(e_valid));
      check("hit_id", 32'(hit_id), 32'(e_id));
      check("fade_level", 32'(fade_level), 32'(e_level));
      check("fade_busy", 32'(fade_busy), 32'(e_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic set_rgb(input int i, input logic [11:0] c);
    layer_rgb[i*PW +: PW] = c;
  endtask

  task automatic pulse_frames(input int n);
    repeat (n) begin
      frame_start = 1'b1; step();
      frame_start = 1'b0; step();
    end
  endtask

  initial begin
    sys_rst = 1'b1; video_on = 1'b0; frame_start = 1'b0; layer_on = '0;
    layer_rgb = '0; layer_mask_wr = 1'b0; layer_mask_in = '0;
    fade_out_req = 1'b0; fade_in_req = 1'b0;
    cyc = 0;
    for (int i = 0; i < LN; i++) set_rgb(i, 12'(12'h111 * (i + 1)));
    step(3);
    check("reset_hit", 32'(hit_id), NONE);
    check("reset_level", 32'(fade_level), LMAX);
    sys_rst = 1'b0;

    // layers 0 and 3 on: layer 0 wins after three cycles
    layer_on = 6'b001001; video_on = 1'b1;
    step(3);
    check("t1_rgb", 32'(rgb), 32'h111);
    check("t1_hit", 32'(hit_id), 0);
    check("t1_valid", 32'(rgb_valid), 1);

    layer_on = '0;
    step(3);
    check("t2_bg", 32'(rgb), 32'(BG));
    check("t2_hit", 32'(hit_id), NONE);
    video_on = 1'b0; layer_on = 6'b001001;
    step(3);
    check("t2_blank_rgb", 32'(rgb), 0);
    check("t2_blank_valid", 32'(rgb_valid), 0);

    // shadow mask waits for frame_start
    video_on = 1'b1;
    layer_mask_wr = 1'b1; layer_mask_in = 6'b111110; step();
    layer_mask_wr = 1'b0; step(3);
    check("t3_before_frame", 32'(hit_id), 0);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    step(3);
    check("t3_after_frame", 32'(hit_id), 3);
    check("t3_rgb", 32'(rgb), 32'h444);
    layer_mask_wr = 1'b1; layer_mask_in = 6'b111111; frame_start = 1'b1; step();
    layer_mask_wr = 1'b0; frame_start = 1'b0;
    step(3);
    check("t3_same_cycle", 32'(hit_id), 0);

    // transparent key colour on layer 0
    layer_on = 6'b000011; set_rgb(0, KEY); set_rgb(1, 12'h0AB);
    step(3);
`ifdef TRANSPARENT_KEY_EN
    check("t6_key_hit", 32'(hit_id), 1);
`else
    check("t6_key_hit", 32'(hit_id), 0);
`endif

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      video_on      = ($urandom % 8) != 0;
      layer_on      = LN'($urandom);
      for (int i = 0; i < LN; i++) set_rgb(i, ($urandom % 5 == 0) ? KEY : 12'($urandom));
      layer_mask_wr = ($urandom % 16) == 0;
      layer_mask_in = LN'($urandom);
      frame_start   = ($urandom % 20) == 0;
      fade_out_req  = ($urandom % 40) == 0;
      fade_in_req   = ($urandom % 40) == 0;
      sys_rst       = ($urandom % 700) == 0;
      step();
    end
    sys_rst = 1'b0; frame_start = 1'b0; layer_mask_wr = 1'b0;
    fade_out_req = 1'b0; fade_in_req = 1'b0;

    // full fade-out
    sys_rst = 1'b1; step(); sys_rst = 1'b0;
    layer_on = 6'b000001; set_rgb(0, WHITE); video_on = 1'b1;
    fade_out_req = 1'b1; step(); fade_out_req = 1'b0;
    check("t4_busy", 32'(fade_busy), 1);
    check("t4_level_start", 32'(fade_level), LMAX);
    pulse_frames(16);
    check("t4_level7", 32'(fade_level), 7);
    step(3);
    check("t4_rgb_777", 32'(rgb), 32'h777);
    pulse_frames(13);
    check("t4_level1", 32'(fade_level), 1);
    check("t4_busy1", 32'(fade_busy), 1);
    pulse_frames(1);
    check("t4_level0", 32'(fade_level), 0);
    check("t4_dark", 32'(fade_busy), 0);
    step(3);
    check("t4_black", 32'(rgb), 0);
    fade_in_req = 1'b1; step(); fade_in_req = 1'b0;
    check("t4_fade_in_busy", 32'(fade_busy), 1);

    // request priority, ignored requests, reset mid-fade
    sys_rst = 1'b1; step(); sys_rst = 1'b0;
    fade_in_req = 1'b1; fade_out_req = 1'b1; step();
    fade_in_req = 1'b0; fade_out_req = 1'b0;
    pulse_frames(2);
    check("t5_out_wins", 32'(fade_level), 14);
    fade_in_req = 1'b1; step(); fade_in_req = 1'b0;
    pulse_frames(2);
    check("t5_in_ignored", 32'(fade_level), 13);
    sys_rst = 1'b1; step(); sys_rst = 1'b0;
    check("t5_rst_level", 32'(fade_level), LMAX);
    check("t5_rst_busy", 32'(fade_busy), 0);
    pulse_frames(2);
    check("t5_bright_hold", 32'(fade_level), LMAX);

    step(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
